// File: rtl/l15_req_arbiter.sv
// Shares the single L1.5 request channel among the core-tile miss ports.
// Grants are held for a whole multi-beat transaction, with a per-port starvation override.
module l15_req_arbiter #(
    parameter int unsigned NumPorts     = 4,
    parameter int unsigned PayloadWidth = 128,
    parameter int unsigned StarveTh     = 16,
    parameter int unsigned CntWidth     = $clog2(StarveTh + 1),
    parameter int unsigned PortWidth    = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                             clk_i,
    input  logic                             reset_l,
    input  logic [NumPorts-1:0]              port_en_i,
    input  logic [NumPorts-1:0]              req_valid_i,
    input  logic [NumPorts-1:0]              req_last_i,
    input  logic [NumPorts*PayloadWidth-1:0] req_data_i,
    output logic [NumPorts-1:0]              req_ready_o,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [PayloadWidth-1:0]          out_data_o,
    output logic                             out_last_o,
    output logic [PortWidth-1:0]             out_port_o,
    output logic                             busy_o,
    output logic                             starve_event_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                             state_q, state_d;
    logic [PortWidth-1:0]               grant_q, grant_d;
    logic                               starve_q, starve_d;
    logic [NumPorts-1:0][CntWidth-1:0]  wait_cnt_q, wait_cnt_d;

    logic [NumPorts-1:0]                    cand;
    logic [NumPorts-1:0]                    starving;
    logic                                   win_valid;
    logic                                   win_starve;
    logic [PortWidth-1:0]                   win_idx;
    logic                                   busy;
    logic                                   fire;
    logic [NumPorts-1:0][PayloadWidth-1:0]  data_arr;

    assign data_arr = req_data_i;
    assign busy     = (state_q == BUSY);
    assign fire     = busy && req_valid_i[grant_q] && out_ready_i;

    // Winner selection: lowest starving candidate, else lowest candidate.
    always_comb begin
        cand       = req_valid_i & port_en_i;
        starving   = '0;
        win_idx    = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            starving[p] = cand[p] && (32'(wait_cnt_q[p]) >= StarveTh);
        end
        win_valid  = |cand;
        win_starve = |starving;
        for (int p = int'(NumPorts) - 1; p >= 0; p--) begin
            if (win_starve ? starving[p] : cand[p]) begin
                win_idx = PortWidth'(p);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        starve_d   = 1'b0;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d  = BUSY;
                    grant_d  = win_idx;
                    starve_d = win_starve;
                end
            end
            BUSY: begin
                if (fire && req_last_i[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Waiting ports age; the winner restarts; disabled ports sit at zero.
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (!port_en_i[p]) begin
                wait_cnt_d[p] = '0;
            end else if (!busy && win_valid && (win_idx == PortWidth'(p))) begin
                wait_cnt_d[p] = '0;
            end else if (cand[p] && !(busy && (grant_q == PortWidth'(p)))
                         && (wait_cnt_q[p] != {CntWidth{1'b1}})) begin
                wait_cnt_d[p] = wait_cnt_q[p] + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            starve_q   <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            starve_q   <= starve_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Data path is a straight mux from the owner; no buffering.
    always_comb begin
        req_ready_o = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            req_ready_o[p] = busy && (grant_q == PortWidth'(p)) && out_ready_i;
        end
    end

    assign out_valid_o    = busy && req_valid_i[grant_q];
    assign out_data_o     = data_arr[grant_q];
    assign out_last_o     = req_last_i[grant_q];
    assign out_port_o     = grant_q;
    assign busy_o         = busy;
    assign starve_event_o = starve_q;

endmodule
